// File: rtl/aes64_pkg.sv
// Shared types for the 64-bit AES packet path: controller states and the FIFO packet layout.
package aes64_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int KEY_W_DEF  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_RDWAIT,
    ST_DEC,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Matches the FIFO word ordering: cipher in the upper half, key in the lower half.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] cipher;
    logic [KEY_W_DEF-1:0]  key;
  } pkt_t;

endpackage

// File: rtl/aes64_lat_timer.sv
// Loadable down-counter; expired is high in the Nth cycle after a load of N (N >= 1).
module aes64_lat_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/aes64_decrypt_reader.sv
// Read-side AES-64 controller: pops {cipher,key} packets, runs the external decrypt engine
// one packet at a time, and streams plaintext with a wrapping sequence tag.
module aes64_decrypt_reader
  import aes64_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int KEY_W       = KEY_W_DEF,
  parameter int FIFO_RD_LAT = 1,
  parameter int DEC_TIMEOUT = 32,
  parameter int SEQ_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    fifo_empty,
  output logic                    fifo_re,
  input  logic [DATA_W+KEY_W-1:0] fifo_rdata,
  output logic                    dec_start,
  output logic [DATA_W-1:0]       dec_cipher,
  output logic [KEY_W-1:0]        dec_key,
  input  logic                    dec_done,
  input  logic [DATA_W-1:0]       dec_plain,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEQ_W-1:0]        out_seq,
  output logic                    busy,
  output logic [SEQ_W-1:0]        timeout_cnt
);

  localparam int TMR_MAX = (DEC_TIMEOUT > FIFO_RD_LAT) ? DEC_TIMEOUT : FIFO_RD_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;
  logic               can_pop;

  assign can_pop = enable && !fifo_empty;

  // One timer serves both the read-latency wait (loaded in POP) and the engine timeout (loaded in DEC).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(DEC_TIMEOUT);
    if (state == ST_POP) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(FIFO_RD_LAT);
    end else if (state == ST_DEC) begin
      tmr_load = 1'b1;
    end
  end

  aes64_lat_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fifo_re     <= 1'b0;
      dec_start   <= 1'b0;
      dec_cipher  <= '0;
      dec_key     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_seq     <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      fifo_re   <= 1'b0;
      dec_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (can_pop) begin
            state   <= ST_POP;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_POP: begin
          state <= ST_RDWAIT;
        end
        ST_RDWAIT: begin
          if (tmr_expired) begin
            dec_cipher <= fifo_rdata[DATA_W+KEY_W-1:KEY_W];
            dec_key    <= fifo_rdata[KEY_W-1:0];
            dec_start  <= 1'b1;
            state      <= ST_DEC;
          end
        end
        ST_DEC: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion landing on the last timeout cycle still counts as delivered.
          if (dec_done) begin
            out_data  <= dec_plain;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (tmr_expired) begin
            if (timeout_cnt != '1) begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_seq   <= out_seq + 1'b1;
            if (can_pop) begin
              state   <= ST_POP;
              fifo_re <= 1'b1;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes64_decrypt_reader.sv
// Directed bench for aes64_decrypt_reader with a behavioural packet FIFO and decrypt engine.
module tb_aes64_decrypt_reader;
  import aes64_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_re;
  logic [127:0] fifo_rdata = '0;
  logic         dec_start;
  logic [63:0]  dec_cipher, dec_key;
  logic         dec_done = 1'b0;
  logic [63:0]  dec_plain = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic [7:0]   out_seq;
  logic         busy;
  logic [7:0]   timeout_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes64_decrypt_reader #(
    .DATA_W(64), .KEY_W(64), .FIFO_RD_LAT(1), .DEC_TIMEOUT(32), .SEQ_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_rdata(fifo_rdata), .dec_start(dec_start), .dec_cipher(dec_cipher), .dec_key(dec_key),
    .dec_done(dec_done), .dec_plain(dec_plain), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_seq(out_seq), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  // Packet FIFO with one-cycle read latency and a registered empty flag.
  pkt_t fifo_q[$];
  always @(posedge clk) begin
    if (fifo_re && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Engine: plaintext = cipher ^ key ^ mask, done eng_lat cycles after dec_start.
  logic [63:0] eng_mask = '0;
  int          eng_lat = 3;
  bit          eng_hang = 1'b0;
  int          eng_rem = 0;
  bit          eng_act = 1'b0;
  always @(posedge clk) begin
    dec_done <= 1'b0;
    if (rst) begin
      eng_act <= 1'b0;
    end else if (dec_start && !eng_hang) begin
      dec_plain <= dec_cipher ^ dec_key ^ eng_mask;
      if (eng_lat == 1) dec_done <= 1'b1;
      else begin
        eng_rem <= eng_lat - 1;
        eng_act <= 1'b1;
      end
    end else if (eng_act) begin
      if (eng_rem == 1) begin
        dec_done <= 1'b1;
        eng_act  <= 1'b0;
      end
      eng_rem <= eng_rem - 1;
    end
  end

  // Observation at the falling edge.
  int cyc = 0, n_re = 0, n_start = 0, re_bad = 0, gap_cnt = 0;
  int re_cyc = 0, valid_cyc = 0, start_cyc = 0, tmo_cyc = 0, gap_target = 0;
  bit track_gap = 1'b0, prev_ok = 1'b0, prev_valid = 1'b0;
  logic [7:0]  prev_tmo = '0;
  logic [63:0] obs_data[$];
  logic [7:0]  obs_seq[$];
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (fifo_re) begin
      n_re++;
      re_cyc = cyc;
      if (!prev_ok) re_bad++;
    end
    if (dec_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (out_valid && !prev_valid) valid_cyc = cyc;
    if (out_valid && out_ready) begin
      obs_data.push_back(out_data);
      obs_seq.push_back(out_seq);
    end
    if (timeout_cnt != prev_tmo) tmo_cyc = cyc;
    if (track_gap && n_re > 0 && obs_data.size() < gap_target && !busy) gap_cnt++;
    prev_ok    = enable && !fifo_empty && !rst;
    prev_valid = out_valid;
    prev_tmo   = timeout_cnt;
  end

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    eng_hang = 1'b0; eng_lat = 3; eng_mask = 64'h5A5A_0000_FFFF_1234;
    fifo_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_re = 0; n_start = 0; re_bad = 0; gap_cnt = 0; track_gap = 1'b0;
    obs_data.delete(); obs_seq.delete(); exp_q.delete();
  endtask

  task automatic push_pkt(input logic [63:0] c, input logic [63:0] k);
    pkt_t p;
    p.cipher = c;
    p.key    = k;
    fifo_q.push_back(p);
    exp_q.push_back(c ^ k ^ eng_mask);
  endtask

  task automatic wait_outs(input int n, input int budget);
    int k = 0;
    while (obs_data.size() < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
    fifo_q.push_back(128'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({fifo_re, dec_start, out_valid, busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {fifo_re, dec_start, out_valid, busy});
    end
    n_chk++;
    if ({dec_cipher, dec_key} !== 128'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h want 0", {dec_cipher, dec_key});
    end
    n_chk++;
    if ({out_data, out_seq, timeout_cnt} !== 80'h0) begin
      n_fail++; $display("FAIL reset_out: got %h want 0", {out_data, out_seq, timeout_cnt});
    end
  endtask

  task automatic test_single();
    logic [63:0] got;
    do_reset();
    eng_lat  = 10;
    eng_mask = 64'h0123456789ABCDEF ^ 64'h0F1E2D3C4B5A6978 ^ 64'hCAFEF00DDEADBEEF;
    push_pkt(64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978);
    out_ready = 1'b1; enable = 1'b1;
    wait_outs(1, 200);
    repeat (5) @(posedge clk);
    @(negedge clk);
    got = (obs_data.size() > 0) ? obs_data[0] : 64'hx;
    n_chk++;
    if (obs_data.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", obs_data.size()); end
    n_chk++;
    if (got !== 64'hCAFEF00DDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want cafef00ddeadbeef", got); end
    n_chk++;
    if (obs_seq.size() != 1 || obs_seq[0] !== 8'd0) begin n_fail++; $display("FAIL single_seq: want seq 0, n=%0d", obs_seq.size()); end
    n_chk++;
    if (n_re != 1 || n_start != 1) begin n_fail++; $display("FAIL single_strobes: fifo_re %0d dec_start %0d want 1 1", n_re, n_start); end
    n_chk++;
    if (valid_cyc - re_cyc != 13) begin n_fail++; $display("FAIL single_latency: got %0d want 13", valid_cyc - re_cyc); end
    n_chk++;
    if (busy !== 1'b0 || fifo_re !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b fifo_re %b want 0 0", busy, fifo_re); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    eng_lat = 4;
    for (int i = 0; i < 10; i++) push_pkt({32'hC0DE0000 + 32'(i), 32'h01234567}, {32'h0, 32'h1111 * 32'(i)});
    gap_target = 10; track_gap = 1'b1;
    out_ready = 1'b1; enable = 1'b1;
    wait_outs(10, 400);
    n_chk++;
    if (obs_data.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", obs_data.size()); end
    for (int i = 0; i < 10 && i < obs_data.size(); i++) begin
      n_chk++;
      if (obs_data[i] !== exp_q[i] || obs_seq[i] !== 8'(i)) begin
        n_fail++; $display("FAIL b2b_pkt%0d: got %h/%0d want %h/%0d", i, obs_data[i], obs_seq[i], exp_q[i], i);
      end
    end
    n_chk++;
    if (n_re != 10 || gap_cnt != 0 || re_bad != 0) begin
      n_fail++; $display("FAIL b2b_flow: fifo_re %0d gaps %0d bad_re %0d want 10 0 0", n_re, gap_cnt, re_bad);
    end
    track_gap = 1'b0;
  endtask

  task automatic test_backpressure();
    int k = 0, bad = 0;
    logic [63:0] hd;
    logic [7:0]  hs;
    do_reset();
    eng_lat = 2;
    for (int i = 0; i < 3; i++) push_pkt(64'hBEEF_0000_0000_0000 | 64'(i), 64'h7777_0000 + 64'(i));
    out_ready = 1'b0; enable = 1'b1;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    hd = out_data; hs = out_seq;
    n_chk++;
    if (hd !== exp_q[0] || hs !== 8'd0) begin n_fail++; $display("FAIL bp_first: got %h/%0d want %h/0", hd, hs, exp_q[0]); end
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data !== hd || out_seq !== hs) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    n_chk++;
    if (n_re != 1) begin n_fail++; $display("FAIL bp_no_pop: fifo_re %0d want 1", n_re); end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_outs(3, 200);
    n_chk++;
    if (obs_data.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", obs_data.size()); end
    for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
      n_chk++;
      if (obs_data[i] !== exp_q[i] || obs_seq[i] !== 8'(i)) begin
        n_fail++; $display("FAIL bp_pkt%0d: got %h/%0d want %h/%0d", i, obs_data[i], obs_seq[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    do_reset();
    eng_hang = 1'b1;
    push_pkt(64'hDEAD_0000_0000_0001, 64'h1);
    out_ready = 1'b1; enable = 1'b1;
    while (timeout_cnt != 8'd1 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (timeout_cnt !== 8'd1 || busy !== 1'b0 || obs_data.size() != 0) begin
      n_fail++; $display("FAIL tmo_drop: cnt %0d busy %b outs %0d want 1 0 0", timeout_cnt, busy, obs_data.size());
    end
    n_chk++;
    if (tmo_cyc - start_cyc != 33) begin n_fail++; $display("FAIL tmo_timing: got %0d want 33", tmo_cyc - start_cyc); end
    @(posedge clk); #1;
    eng_hang = 1'b0; eng_lat = 32;
    push_pkt(64'h0000_5555_AAAA_0002, 64'h2);
    wait_outs(1, 100);
    n_chk++;
    if (obs_data.size() != 1 || obs_data[0] !== exp_q[1] || obs_seq[0] !== 8'd0 || timeout_cnt !== 8'd1) begin
      n_fail++; $display("FAIL tmo_edge_done: outs %0d cnt %0d want 1 output seq 0 cnt 1", obs_data.size(), timeout_cnt);
    end
    eng_lat = 33;
    push_pkt(64'h3, 64'h3);
    k = 0;
    while (timeout_cnt != 8'd2 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (timeout_cnt !== 8'd2 || obs_data.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_late_done: cnt %0d outs %0d busy %b want 2 1 0", timeout_cnt, obs_data.size(), busy);
    end
  endtask

  task automatic test_seq_wrap();
    int bad = 0;
    do_reset();
    eng_lat = 1;
    for (int i = 0; i < 257; i++) push_pkt({32'(i), 32'hA5A5A5A5}, {32'h0, 32'(i * 3)});
    out_ready = 1'b1; enable = 1'b1;
    wait_outs(257, 3000);
    n_chk++;
    if (obs_data.size() != 257) begin n_fail++; $display("FAIL wrap_count: got %0d want 257", obs_data.size()); end
    for (int i = 0; i < 257 && i < obs_data.size(); i++) begin
      n_chk++;
      if (obs_seq[i] !== 8'(i) || obs_data[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_pkt%0d: got %h/%0d want %h/%0d", i, obs_data[i], obs_seq[i], exp_q[i], i % 256);
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (fifo_re !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0 || n_re != 257 || re_bad != 0) begin
      n_fail++; $display("FAIL wrap_empty: bad %0d fifo_re %0d bad_re %0d want 0 257 0", bad, n_re, re_bad);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    eng_lat = 2;
    push_pkt(64'h1111, 64'h2222);
    out_ready = 1'b1; enable = 1'b1;
    wait_outs(1, 100);
    eng_lat = 20;
    push_pkt(64'h3333, 64'h4444);
    push_pkt(64'h5555, 64'h6666);
    while (n_start < 2 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; enable = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if ({fifo_re, dec_start, out_valid, busy} !== 4'b0 || {dec_cipher, dec_key, out_data, out_seq, timeout_cnt} !== 208'h0) begin
      n_fail++; $display("FAIL rst_wait: ctrl %b seq %0d data %h want all 0", {fifo_re, dec_start, out_valid, busy}, out_seq, out_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    eng_lat = 2; out_ready = 1'b0; enable = 1'b1;
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if ({fifo_re, dec_start, out_valid, busy} !== 4'b0 || {out_data, out_seq} !== 72'h0) begin
      n_fail++; $display("FAIL rst_out: ctrl %b seq %0d data %h want all 0", {fifo_re, dec_start, out_valid, busy}, out_seq, out_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    push_pkt(64'h7777, 64'h8888);
    out_ready = 1'b1; enable = 1'b1;
    wait_outs(2, 100);
    n_chk++;
    if (obs_data.size() != 2 || obs_data[1] !== exp_q[3] || obs_seq[1] !== 8'd0) begin
      n_fail++; $display("FAIL rst_resume: outs %0d want 2 with seq 0 data %h", obs_data.size(), exp_q[3]);
    end
  endtask

  task automatic test_enable_drop();
    int k = 0;
    do_reset();
    eng_lat = 6;
    for (int i = 0; i < 3; i++) push_pkt(64'hE0 + 64'(i), 64'h9);
    out_ready = 1'b1; enable = 1'b1;
    while (n_start < 1 && k < 50) begin @(posedge clk); #1; k++; end
    enable = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (obs_data.size() != 1 || obs_data[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL en_complete: outs %0d want 1 with data %h", obs_data.size(), exp_q[0]);
    end
    n_chk++;
    if (n_re != 1 || busy !== 1'b0 || re_bad != 0) begin
      n_fail++; $display("FAIL en_no_pop: fifo_re %0d busy %b bad_re %0d want 1 0 0", n_re, busy, re_bad);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_seq_wrap();
    test_reset_mid();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
